// File: rtl/mem_burst_pkg.sv
// rtl/mem_burst_pkg.sv - shared state encoding and default widths for the burst controller
package mem_burst_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_LEN_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } burst_state_t;

endpackage

// File: rtl/mem_burst_rdbuf.sv
// rtl/mem_burst_rdbuf.sv - 2-entry read-data FIFO between memory and the read stream
module mem_burst_rdbuf
    import mem_burst_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic                  o_valid,
    output logic                  o_full,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    assign o_valid   = (r_count != 2'd0);
    assign o_full    = (r_count == 2'd2);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && o_valid;
    // A full buffer can still take a push when the head leaves in the same cycle.
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
        end
    end

endmodule

// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - burst read/write engine turning one command into a run of memory strobes
module mem_burst_ctrl
    import mem_burst_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [LEN_WIDTH-1:0]  i_cmd_len,
    input  logic                  i_wdata_valid,
    output logic                  o_wdata_ready,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_rdata_valid,
    input  logic                  i_rdata_ready,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_done,
    output logic                  o_mem_wr_en,
    output logic                  o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0] o_mem_address,
    output logic [DATA_WIDTH-1:0] o_mem_wr_data,
    input  logic [DATA_WIDTH-1:0] i_mem_rd_data
);

    burst_state_t          r_state;
    burst_state_t          w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_inflight;
    logic                  r_done;
    logic                  w_accept;
    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic                  w_pop;
    logic                  w_drain_done;
    logic                  w_last;
    logic [1:0]            w_occ_after_pop;
    logic                  w_buf_valid;
    logic                  w_buf_full;
    logic [DATA_WIDTH-1:0] w_buf_data;

    mem_burst_rdbuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rdbuf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (r_inflight),
        .i_push_data (i_mem_rd_data),
        .i_pop       (w_pop),
        .o_valid     (w_buf_valid),
        .o_full      (w_buf_full),
        .o_data      (w_buf_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_accept        = 1'b0;
        w_wr_fire       = 1'b0;
        w_rd_fire       = 1'b0;
        w_drain_done    = 1'b0;
        w_last          = (r_remaining == LEN_WIDTH'(1));
        w_pop           = w_buf_valid && i_rdata_ready && !i_rst;
        // Occupancy after this cycle's pop, so a steady stream keeps one word per cycle.
        w_occ_after_pop = (w_buf_full ? 2'd2 : (w_buf_valid ? 2'd1 : 2'd0)) - {1'b0, w_pop};
        case (r_state)
            ST_IDLE: begin
                if (i_cmd_valid && !i_rst) begin
                    w_accept = 1'b1;
                    if (i_cmd_len != '0) begin
                        w_next_state = i_cmd_write ? ST_WRITE : ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                if (i_wdata_valid && !i_rst) begin
                    w_wr_fire = 1'b1;
                    if (w_last) begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                if (!i_rst && ((w_occ_after_pop + {1'b0, r_inflight}) < 2'd2)) begin
                    w_rd_fire = 1'b1;
                    if (w_last) begin
                        w_next_state = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!r_inflight && w_pop && !w_buf_full) begin
                    w_drain_done = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_inflight <= w_rd_fire;
            r_done     <= (w_accept && (i_cmd_len == '0)) || (w_wr_fire && w_last);
            if (w_accept) begin
                r_addr      <= i_cmd_addr;
                r_remaining <= i_cmd_len;
            end else if (w_wr_fire || w_rd_fire) begin
                r_addr      <= r_addr + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - LEN_WIDTH'(1);
            end
        end
    end

    assign o_cmd_ready   = !i_rst && (r_state == ST_IDLE);
    assign o_wdata_ready = !i_rst && (r_state == ST_WRITE);
    assign o_mem_wr_en   = w_wr_fire;
    assign o_mem_rd_en   = w_rd_fire;
    assign o_mem_address = i_rst ? '0 : r_addr;
    assign o_mem_wr_data = w_wr_fire ? i_wdata : '0;
    assign o_rdata_valid = w_buf_valid && !i_rst;
    assign o_rdata       = o_rdata_valid ? w_buf_data : '0;
    assign o_done        = !i_rst && (r_done || w_drain_done);

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb/tb_mem_burst_ctrl.sv - randomized self-checking bench for mem_burst_ctrl
module tb_mem_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_len;
    logic       wdata_valid, wdata_ready;
    logic [7:0] wdata;
    logic       rdata_valid, rdata_ready;
    logic [7:0] rdata;
    logic       done, mem_wr_en, mem_rd_en;
    logic [7:0] mem_addr, mem_wr_data, mem_rd_data;

    int n_checks = 0;
    int n_fail   = 0;
    int outstanding = 0;
    int done_cnt = 0;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  wbuf    [256];
    logic [15:0] wq  [$];
    logic [7:0]  raq [$];
    logic [7:0]  rdq [$];
    logic [15:0] mon_e;
    logic [7:0]  mon_b;
    logic        rd_pend = 1'b0;
    logic [7:0]  rd_pend_addr = 8'h0;

    always #5 clk = ~clk;

    mem_burst_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LEN_WIDTH(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
        .i_wdata_valid(wdata_valid), .o_wdata_ready(wdata_ready), .i_wdata(wdata),
        .o_rdata_valid(rdata_valid), .i_rdata_ready(rdata_ready), .o_rdata(rdata),
        .o_done(done), .o_mem_wr_en(mem_wr_en), .o_mem_rd_en(mem_rd_en),
        .o_mem_address(mem_addr), .o_mem_wr_data(mem_wr_data), .i_mem_rd_data(mem_rd_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Memory behind the DUT: writes land at once, read data appears one cycle after the strobe.
    always @(negedge clk) begin
        if (mem_wr_en) mem[mem_addr] = mem_wr_data;
        rd_pend      = mem_rd_en;
        rd_pend_addr = mem_addr;
    end

    always @(posedge clk) begin
        #1;
        mem_rd_data = rd_pend ? mem[rd_pend_addr] : 8'($urandom);
    end

    always @(negedge clk) begin
        if (!rst) begin
            check_eq("strobe_excl", 32'(mem_wr_en & mem_rd_en), 32'd0);
            if (mem_wr_en) begin
                if (wq.size() == 0) check_eq("wr_unexpected", 32'(mem_wr_en), 32'd0);
                else begin
                    mon_e = wq.pop_front();
                    check_eq("wr_addr", 32'(mem_addr), 32'(mon_e[15:8]));
                    check_eq("wr_data", 32'(mem_wr_data), 32'(mon_e[7:0]));
                end
            end
            if (mem_rd_en) begin
                outstanding++;
                if (raq.size() == 0) check_eq("rd_unexpected", 32'(mem_rd_en), 32'd0);
                else begin
                    mon_b = raq.pop_front();
                    check_eq("rd_addr", 32'(mem_addr), 32'(mon_b));
                end
            end
            if (rdata_valid && rdata_ready) begin
                outstanding--;
                if (rdq.size() == 0) check_eq("rdata_unexpected", 32'(rdata_valid), 32'd0);
                else begin
                    mon_b = rdq.pop_front();
                    check_eq("rdata", 32'(rdata), 32'(mon_b));
                end
            end
            check_eq("rd_outstanding_le2", 32'(outstanding > 2), 32'd0);
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input bit wr, input logic [7:0] addr, input logic [7:0] len);
        int t = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        @(negedge clk);
        while (!cmd_ready && t < 20) begin
            tick();
            @(negedge clk);
            t++;
        end
        check_eq("cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // mode: write 0=continuous 1=random valid; read 0=always ready 1=toggle 2=random
    task automatic run_burst(input bit wr, input logic [7:0] addr, input logic [7:0] len, input int mode);
        int d0, cyc, k, first_pop, last_pop;
        d0 = done_cnt;
        for (int i = 0; i < int'(len); i++) begin
            if (wr) begin
                wq.push_back({8'(int'(addr) + i), wbuf[i]});
                ref_mem[8'(int'(addr) + i)] = wbuf[i];
            end else begin
                raq.push_back(8'(int'(addr) + i));
                rdq.push_back(ref_mem[8'(int'(addr) + i)]);
            end
        end
        send_cmd(wr, addr, len);
        k = 0; cyc = 0; first_pop = -1; last_pop = -1;
        if (len == 8'd0) begin
            @(negedge clk);
            check_eq("len0_done", 32'(done), 32'd1);
            check_eq("len0_ready", 32'(cmd_ready), 32'd1);
            tick();
        end else if (wr) begin
            while (k < int'(len) && cyc < 8 * int'(len) + 20) begin
                wdata_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                wdata = wbuf[k];
                @(negedge clk);
                if (wdata_valid && wdata_ready) k++;
                cyc++;
                tick();
            end
            wdata_valid = 1'b0;
            check_eq("wr_all_taken", 32'(k), 32'(len));
            if (mode == 0) check_eq("wr_cycles", 32'(cyc), 32'(len));
            @(negedge clk);
            check_eq("wr_done", 32'(done), 32'd1);
            tick();
        end else begin
            while (k < int'(len) && cyc < 8 * int'(len) + 20) begin
                rdata_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
                @(negedge clk);
                if (rdata_valid && rdata_ready) begin
                    if (first_pop < 0) first_pop = cyc;
                    last_pop = cyc;
                    k++;
                    if (k == int'(len)) check_eq("rd_done_last_pop", 32'(done), 32'd1);
                end
                cyc++;
                tick();
            end
            rdata_ready = 1'b0;
            check_eq("rd_all_popped", 32'(k), 32'(len));
            if (mode == 0) begin
                check_eq("rd_first_latency", 32'(first_pop), 32'd2);
                check_eq("rd_consecutive", 32'(last_pop - first_pop + 1), 32'(len));
            end
        end
        @(negedge clk);
        check_eq("done_once", 32'(done_cnt - d0), 32'd1);
        check_eq("wq_empty", 32'(wq.size()), 32'd0);
        check_eq("raq_empty", 32'(raq.size()), 32'd0);
        check_eq("rdq_empty", 32'(rdq.size()), 32'd0);
        check_eq("idle_ready", 32'(cmd_ready), 32'd1);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0; mem_rd_data = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        tick();
        repeat (2) begin
            @(negedge clk);
            check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
            check_eq("rst_outputs", 32'({done, mem_wr_en, mem_rd_en, rdata_valid, wdata_ready}), 32'd0);
            check_eq("rst_addr", 32'(mem_addr), 32'd0);
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("post_rst_done", 32'(done), 32'd0);
        tick();

        for (int i = 0; i < 8; i++) wbuf[i] = 8'(8'hA0 + i);
        run_burst(1'b1, 8'h01, 8'd8, 0);
        run_burst(1'b0, 8'h01, 8'd8, 0);
        run_burst(1'b0, 8'h04, 8'd20, 1);
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        run_burst(1'b1, 8'hFE, 8'd4, 0);
        run_burst(1'b0, 8'hFE, 8'd4, 2);
        run_burst(1'b1, 8'h33, 8'd0, 0);
        run_burst(1'b0, 8'h44, 8'd0, 0);

        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 256; i++) wbuf[i] = 8'($urandom);
            run_burst(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 24)), int'($urandom_range(0, 2)));
        end

        for (int i = 0; i < 256; i++) wbuf[i] = 8'($urandom);
        run_burst(1'b1, 8'h80, 8'd255, 1);
        run_burst(1'b0, 8'h80, 8'd255, 2);

        for (int i = 0; i < 20; i++) begin
            raq.push_back(8'(8'h10 + i));
            rdq.push_back(ref_mem[8'(8'h10 + i)]);
        end
        send_cmd(1'b0, 8'h10, 8'd20);
        rdata_ready = 1'b0;
        repeat (4) begin @(negedge clk); tick(); end
        rdata_ready = 1'b1;
        repeat (2) begin @(negedge clk); tick(); end
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_strobes", 32'({mem_wr_en, mem_rd_en}), 32'd0);
        check_eq("abort_rdata_valid", 32'(rdata_valid), 32'd0);
        check_eq("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        raq.delete();
        rdq.delete();
        outstanding = 0;
        tick();
        rst = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        check_eq("abort_release_ready", 32'(cmd_ready), 32'd1);
        check_eq("abort_release_rdata", 32'(rdata_valid), 32'd0);
        tick();
        repeat (5) begin @(negedge clk); tick(); end
        check_eq("abort_no_done", 32'(done_cnt - d0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
